alarm_unit: RTL and testbench
=============================

# alarm_unit

Alarm stage directly downstream of the `hmsv2` timekeeper. It consumes the live `hrs`/`min`/`sec` outputs and holds a user-programmable alarm time (hours/minutes) edited with its own mode/inc/dec pulses. It raises `ringing` when the clock reaches the alarm time, and supports snooze, stop, disarm and automatic ring timeout. Button inputs are single-cycle pulses, in the same form the timekeeper receives.

## Interface
Parameters:
- `SNOOZE_MIN`, default 5: snooze length in minutes, legal range 1..59.
- `RING_SEC`, default 60: seconds the alarm rings before giving up, legal range 1..255.

Ports:
- `clk` in 1: system clock, the single clock domain.
- `rst` in 1: reset, synchronous, active-high.
- `hrs` in 5: current hours 0..23, from `hmsv2`.
- `min` in 6: current minutes 0..59, from `hmsv2`.
- `sec` in 6: current seconds 0..59, from `hmsv2`.
- `set_en` in 1: level; alarm-set mode is active while high.
- `sel` in 1: pulse; toggles the edited field between hours and minutes.
- `inc` in 1: pulse; increments the selected field.
- `dec` in 1: pulse; decrements the selected field.
- `arm` in 1: level; alarm enabled while high.
- `snooze` in 1: pulse; snoozes an active ring.
- `stop` in 1: pulse; cancels the ring or snooze.
- `al_hrs` out 5: programmed alarm hours.
- `al_min` out 6: programmed alarm minutes.
- `field` out 1: edited field; 0 = hours, 1 = minutes.
- `ringing` out 1: high while in RING.
- `snoozed` out 1: high while in SNOOZE.

## Operation
- **Reset values:** `al_hrs` = 0, `al_min` = 0, `field` = 0, `ringing` = 0, `snoozed` = 0, state IDLE, all counters 0, `sec_q` = 0.
- **Second tick:** `tick` = (`sec` != `sec_q`). `sec_q` registers `sec` every cycle. The block has no other timebase.
- **Editing:** edits happen only while `set_en` = 1. Pulses outside set mode are ignored for editing.
  - `inc` on hours: 23 wraps to 0. `dec` on hours: 0 wraps to 23.
  - `inc` on minutes: 59 wraps to 0. `dec` on minutes: 0 wraps to 59.
  - `inc` and `dec` in the same cycle: no change.
  - `sel` in the same cycle as `inc`/`dec`: the edit applies to the old field, then `field` toggles.
  - `field` returns to 0 when `set_en` falls.
- **Match:** `match` = `arm` & !`set_en` & `tick` & (`sec` == 0) & (`hrs` == `al_hrs`) & (`min` == `al_min`).
- **FSM states:** IDLE, RING, SNOOZE.
  - IDLE -> RING on `match`. `ring_cnt` clears to 0.
  - RING:
    - -> IDLE on `stop`.
    - -> SNOOZE on `snooze`. `snz_cnt` loads SNOOZE_MIN*60.
    - Otherwise `ring_cnt` increments on each `tick`. When `ring_cnt` reaches RING_SEC-1 and a `tick` occurs -> IDLE (timeout).
  - SNOOZE:
    - -> IDLE on `stop`.
    - Otherwise `snz_cnt` decrements on each `tick`. On the tick with `snz_cnt` == 1 -> RING, and `ring_cnt` clears.
  - From any state -> IDLE when `arm` = 0 or `set_en` = 1. This has priority over all other transitions.
  - In RING, `stop` and `snooze` in the same cycle: `stop` wins.
- **Counter widths:** `ring_cnt` is 8 bits. `snz_cnt` is 12 bits (max 3540).
- **Retrigger rule:** no retrigger within the same minute, because a match needs a tick into `sec` == 0. After timeout or stop, the next ring is 24 h later.
- **Outputs:** `ringing` = (state == RING). `snoozed` = (state == SNOOZE). Both are registered.

## Timing
- Every output is registered and changes only on the `clk` rising edge.
- `ringing` rises one edge after the first cycle in which `sec` shows 0 at the matching `hrs`/`min`.
- Edit pulses are visible on `al_hrs`/`al_min` after one edge.
- `stop`, `snooze`, `arm` deassert and `set_en` assert each take effect on the next edge.
- RING lasts exactly RING_SEC ticks. SNOOZE lasts exactly SNOOZE_MIN*60 ticks.
- `rst` mid-ring or mid-snooze: next edge returns the block to reset values, including the alarm time.
- `sec` held constant (clock stopped): no ticks, so the counters freeze and no match occurs.

## Test plan
- **Hour wrap and field select:** reset, `set_en`=1, 3× `dec` -> `al_hrs`=21. `sel`, 2× `dec` -> `al_min`=58, `field`=1. `set_en`=0 -> `field`=0.
- **Alarm trigger:** alarm 07:30, `arm`=1. Drive time 07:29:59 -> 07:30:00 -> `ringing`=1 one edge later. Alarm 07:31 at the same time -> `ringing` stays 0.
- **Ring timeout:** RING_SEC=3. Ring, then 3 sec steps -> `ringing`=0 after the 3rd tick. Hold at 07:30:00+ -> no retrigger.
- **Snooze:** SNOOZE_MIN=1. Ring, then `snooze` -> `snoozed`=1, `ringing`=0. After 60 ticks -> `ringing`=1, `snoozed`=0. Then `stop` -> both 0.
- **Priority:** `stop`+`snooze` in the same cycle -> IDLE. `arm`=0 during SNOOZE -> IDLE next edge. `set_en`=1 during RING -> IDLE.
- **Reset mid-ring:** `rst` pulse while `ringing`=1 -> all outputs 0 and alarm time 00:00 next edge. `inc`+`dec` together in set mode -> no change.

Source files
------------

// File: rtl/alarm_unit.sv
// Alarm stage fed by the hmsv2 timekeeper. It holds a programmable alarm
// time (hours/minutes), rings when the live time reaches it, and supports
// snooze, stop, disarm and an automatic ring timeout.
module alarm_unit #(
    parameter int unsigned SNOOZE_MIN = 5,
    parameter int unsigned RING_SEC   = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] hrs,
    input  logic [5:0] min,
    input  logic [5:0] sec,
    input  logic       set_en,
    input  logic       sel,
    input  logic       inc,
    input  logic       dec,
    input  logic       arm,
    input  logic       snooze,
    input  logic       stop,
    output logic [4:0] al_hrs,
    output logic [5:0] al_min,
    output logic       field,
    output logic       ringing,
    output logic       snoozed
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2
    } state_e;

    // Last ring_cnt value before timeout and the snooze reload, in ticks.
    localparam logic [7:0]  RING_LAST = 8'(RING_SEC - 1);
    localparam logic [11:0] SNZ_LOAD  = 12'(SNOOZE_MIN * 60);

    state_e      state_q, state_d;
    logic [4:0]  al_hrs_q, al_hrs_d;
    logic [5:0]  al_min_q, al_min_d;
    logic        field_q, field_d;
    logic [7:0]  ring_cnt_q, ring_cnt_d;
    logic [11:0] snz_cnt_q, snz_cnt_d;
    logic [5:0]  sec_q;
    logic        ringing_q, ringing_d;
    logic        snoozed_q, snoozed_d;

    logic tick;
    logic match;

    // A change of the seconds value is the only timebase available here.
    assign tick  = (sec != sec_q);
    // Requiring the tick into second 0 prevents a retrigger within the minute.
    assign match = arm && !set_en && tick && (sec == 6'd0) &&
                   (hrs == al_hrs_q) && (min == al_min_q);

    // Alarm-time editing: wrap-around inc/dec on the selected field.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        al_hrs_d = al_hrs_q;
        al_min_d = al_min_q;
        field_d  = field_q;
        if (set_en) begin
            // inc and dec together cancel; the edit uses the field before sel.
            if (inc && !dec) begin
                if (field_q) al_min_d = (al_min_q == 6'd59) ? 6'd0 : al_min_q + 6'd1;
                else         al_hrs_d = (al_hrs_q == 5'd23) ? 5'd0 : al_hrs_q + 5'd1;
            end else if (dec && !inc) begin
                if (field_q) al_min_d = (al_min_q == 6'd0) ? 6'd59 : al_min_q - 6'd1;
                else         al_hrs_d = (al_hrs_q == 5'd0) ? 5'd23 : al_hrs_q - 5'd1;
            end
            if (sel) field_d = ~field_q;
        end else begin
            field_d = 1'b0;
        end
    end

    // Ring/snooze FSM next state and counters; disarm or set mode overrides all.
    always_comb begin
        state_d    = state_q;
        ring_cnt_d = ring_cnt_q;
        snz_cnt_d  = snz_cnt_q;
        if (!arm || set_en) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (match) begin
                        state_d    = RING;
                        ring_cnt_d = 8'd0;
                    end
                end
                RING: begin
                    if (stop) begin
                        state_d = IDLE;
                    end else if (snooze) begin
                        state_d   = SNOOZE;
                        snz_cnt_d = SNZ_LOAD;
                    end else if (tick) begin
                        if (ring_cnt_q == RING_LAST) state_d = IDLE;
                        else                          ring_cnt_d = ring_cnt_q + 8'd1;
                    end
                end
                SNOOZE: begin
                    if (stop) begin
                        state_d = IDLE;
                    end else if (tick) begin
                        if (snz_cnt_q == 12'd1) begin
                            state_d    = RING;
                            ring_cnt_d = 8'd0;
                        end else begin
                            snz_cnt_d = snz_cnt_q - 12'd1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        ringing_d = (state_d == RING);
        snoozed_d = (state_d == SNOOZE);
    end

    // State register; reset also clears the programmed alarm time.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            al_hrs_q   <= 5'd0;
            al_min_q   <= 6'd0;
            field_q    <= 1'b0;
            ring_cnt_q <= 8'd0;
            snz_cnt_q  <= 12'd0;
            sec_q      <= 6'd0;
            ringing_q  <= 1'b0;
            snoozed_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all flops update from pre-edge values.
            state_q    <= state_d;
            al_hrs_q   <= al_hrs_d;
            al_min_q   <= al_min_d;
            field_q    <= field_d;
            ring_cnt_q <= ring_cnt_d;
            snz_cnt_q  <= snz_cnt_d;
            sec_q      <= sec;
            ringing_q  <= ringing_d;
            snoozed_q  <= snoozed_d;
        end
    end

    assign al_hrs  = al_hrs_q;
    assign al_min  = al_min_q;
    assign field   = field_q;
    assign ringing = ringing_q;
    assign snoozed = snoozed_q;

endmodule

// File: tb/tb_alarm_unit.sv
// Self-checking bench for alarm_unit: directed scenarios plus a random run,
// all compared against a time-remaining reference model of the alarm.
module tb_alarm_unit;

    localparam int SNZ_MIN = 1;
    localparam int RING_S  = 3;
    localparam int M_IDLE = 0, M_RING = 1, M_SNOOZE = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] t_hrs = '0;
    logic [5:0] t_min = '0, t_sec = '0;
    logic       set_en = 0, sel = 0, inc = 0, dec = 0, arm = 0, snooze = 0, stop = 0;
    logic [4:0] al_hrs;
    logic [5:0] al_min;
    logic       field, ringing, snoozed;

    int checks = 0;
    int errors = 0;
    int tod = 0;   // time of day in seconds driven to the DUT

    // Reference model state
    int m_al_h, m_al_m, m_mode, m_ring_left, m_snz_left, m_prev_sec;
    bit m_field;

    alarm_unit #(.SNOOZE_MIN(SNZ_MIN), .RING_SEC(RING_S)) dut (
        .clk(clk), .rst(rst), .hrs(t_hrs), .min(t_min), .sec(t_sec),
        .set_en(set_en), .sel(sel), .inc(inc), .dec(dec), .arm(arm),
        .snooze(snooze), .stop(stop), .al_hrs(al_hrs), .al_min(al_min),
        .field(field), .ringing(ringing), .snoozed(snoozed)
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] dut_vec();
        return {al_hrs, al_min, field, ringing, snoozed};
    endfunction

    function automatic logic [13:0] model_vec();
        return {5'(m_al_h), 6'(m_al_m), m_field, m_mode == M_RING, m_mode == M_SNOOZE};
    endfunction

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        bit tk, mt;
        int delta;
        if (rst) begin
            m_al_h = 0; m_al_m = 0; m_field = 0; m_mode = M_IDLE;
            m_ring_left = 0; m_snz_left = 0; m_prev_sec = 0;
            return;
        end
        tk = (int'(t_sec) != m_prev_sec);
        mt = arm && !set_en && tk && t_sec == 0 &&
             int'(t_hrs) == m_al_h && int'(t_min) == m_al_m;
        if (!arm || set_en) begin
            m_mode = M_IDLE;
        end else if (m_mode == M_IDLE) begin
            if (mt) begin m_mode = M_RING; m_ring_left = RING_S; end
        end else if (m_mode == M_RING) begin
            if (stop) m_mode = M_IDLE;
            else if (snooze) begin m_mode = M_SNOOZE; m_snz_left = SNZ_MIN * 60; end
            else if (tk) begin
                m_ring_left--;
                if (m_ring_left == 0) m_mode = M_IDLE;
            end
        end else begin
            if (stop) m_mode = M_IDLE;
            else if (tk) begin
                m_snz_left--;
                if (m_snz_left == 0) begin m_mode = M_RING; m_ring_left = RING_S; end
            end
        end
        if (set_en) begin
            delta = int'(inc) - int'(dec);
            if (m_field) m_al_m = (m_al_m + delta + 60) % 60;
            else         m_al_h = (m_al_h + delta + 24) % 24;
            if (sel) m_field = !m_field;
        end else begin
            m_field = 0;
        end
        m_prev_sec = int'(t_sec);
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_tod();
        t_hrs = 5'(tod / 3600);
        t_min = 6'((tod / 60) % 60);
        t_sec = 6'(tod % 60);
    endtask

    task automatic next_sec();
        tod = (tod + 1) % 86400;
        drive_tod();
    endtask

    // Program the alarm through the edit pulses, steering by the model's value.
    task automatic set_alarm(input int h, input int m);
        set_en = 1; cycle();
        while (m_al_h != h) begin inc = 1; cycle(); inc = 0; end
        sel = 1; cycle(); sel = 0;
        while (m_al_m != m) begin inc = 1; cycle(); inc = 0; end
        set_en = 0; cycle();
    endtask

    // Walk the time into the alarm minute; the DUT should ring after the last edge.
    task automatic ring_now();
        tod = (m_al_h * 3600 + m_al_m * 60 + 86399) % 86400;
        drive_tod(); cycle(); cycle();
        next_sec(); cycle();
    endtask

    task automatic test_reset();
        rst = 1; cycle(); rst = 0;
        checks++;
        if (dut_vec() !== 14'd0) begin
            errors++; $display("FAIL reset: got %h want %h", dut_vec(), 14'd0);
        end
    endtask

    task automatic test_edit();
        set_en = 1; cycle();
        for (int i = 0; i < 3; i++) begin dec = 1; cycle(); dec = 0; end
        checks++;
        if (al_hrs !== 5'd21) begin errors++; $display("FAIL hour_wrap: got %0d want 21", al_hrs); end
        sel = 1; cycle(); sel = 0;
        for (int i = 0; i < 2; i++) begin dec = 1; cycle(); dec = 0; end
        checks++;
        if ({al_min, field} !== {6'd58, 1'b1}) begin
            errors++; $display("FAIL min_wrap: got min=%0d field=%0d want 58/1", al_min, field);
        end
        set_en = 0; cycle();
        checks++;
        if (field !== 1'b0) begin errors++; $display("FAIL field_clear: got %0d want 0", field); end
        // random edit sequence in set mode, including sel coinciding with inc/dec
        set_en = 1;
        for (int i = 0; i < 60; i++) begin
            sel = 1'($urandom_range(0, 3) == 0);
            inc = 1'($urandom_range(0, 1));
            dec = 1'($urandom_range(0, 1));
            cycle();
            sel = 0; inc = 0; dec = 0;
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++; $display("FAIL edit_rand[%0d]: got %h want %h", i, dut_vec(), model_vec());
            end
        end
        set_en = 0; cycle();
    endtask

    task automatic test_trigger();
        set_alarm(7, 30);
        arm = 1;
        tod = 7 * 3600 + 29 * 60 + 58; drive_tod(); cycle(); cycle();
        next_sec(); cycle(); cycle();
        checks++;
        if (ringing !== 1'b0) begin errors++; $display("FAIL early_ring: got %0d want 0", ringing); end
        next_sec(); cycle();
        checks++;
        if (ringing !== 1'b1 || dut_vec() !== model_vec()) begin
            errors++; $display("FAIL trigger: got %h want %h", dut_vec(), model_vec());
        end
        stop = 1; cycle(); stop = 0;
        checks++;
        if (ringing !== 1'b0) begin errors++; $display("FAIL stop: got %0d want 0", ringing); end
        set_alarm(7, 31);
        tod = 7 * 3600 + 29 * 60 + 59; drive_tod(); cycle(); cycle();
        next_sec(); cycle(); cycle(); cycle();
        checks++;
        if (ringing !== 1'b0 || dut_vec() !== model_vec()) begin
            errors++; $display("FAIL no_match: got %h want %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_timeout();
        set_alarm(7, 30);
        ring_now();
        checks++;
        if (ringing !== 1'b1) begin errors++; $display("FAIL timeout_start: got %0d want 1", ringing); end
        for (int k = 1; k <= RING_S; k++) begin
            cycle();             // seconds held: no tick, count frozen
            next_sec(); cycle();
            checks++;
            if (ringing !== 1'(k < RING_S) || dut_vec() !== model_vec()) begin
                errors++; $display("FAIL timeout_tick%0d: got %h want %h", k, dut_vec(), model_vec());
            end
        end
        for (int k = 0; k < 8; k++) begin next_sec(); cycle(); cycle(); end
        checks++;
        if (ringing !== 1'b0 || snoozed !== 1'b0) begin
            errors++; $display("FAIL retrigger: got ring=%0d snz=%0d want 0/0", ringing, snoozed);
        end
    endtask

    task automatic test_snooze();
        ring_now();
        snooze = 1; cycle(); snooze = 0;
        checks++;
        if ({ringing, snoozed} !== 2'b01) begin
            errors++; $display("FAIL snooze_enter: got %b want 01", {ringing, snoozed});
        end
        for (int k = 1; k <= SNZ_MIN * 60; k++) begin
            next_sec(); cycle(); cycle();
            if (k >= SNZ_MIN * 60 - 1) begin
                checks++;
                if ({ringing, snoozed} !== (k == SNZ_MIN * 60 ? 2'b10 : 2'b01)) begin
                    errors++; $display("FAIL snooze_tick%0d: got %b", k, {ringing, snoozed});
                end
            end
        end
        stop = 1; cycle(); stop = 0;
        checks++;
        if ({ringing, snoozed} !== 2'b00 || dut_vec() !== model_vec()) begin
            errors++; $display("FAIL snooze_stop: got %h want %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_priority();
        ring_now();
        stop = 1; snooze = 1; cycle(); stop = 0; snooze = 0;
        checks++;
        if ({ringing, snoozed} !== 2'b00) begin
            errors++; $display("FAIL stop_vs_snooze: got %b want 00", {ringing, snoozed});
        end
        ring_now();
        snooze = 1; cycle(); snooze = 0;
        arm = 0; cycle(); arm = 1;
        checks++;
        if ({ringing, snoozed} !== 2'b00) begin
            errors++; $display("FAIL disarm_snooze: got %b want 00", {ringing, snoozed});
        end
        ring_now();
        set_en = 1; cycle(); set_en = 0;
        checks++;
        if ({ringing, snoozed} !== 2'b00 || dut_vec() !== model_vec()) begin
            errors++; $display("FAIL set_during_ring: got %h want %h", dut_vec(), model_vec());
        end
        cycle();
    endtask

    task automatic test_reset_mid_ring();
        set_alarm(5, 45);
        ring_now();
        checks++;
        if (ringing !== 1'b1) begin errors++; $display("FAIL pre_reset_ring: got %0d want 1", ringing); end
        rst = 1; cycle(); rst = 0;
        checks++;
        if (dut_vec() !== 14'd0) begin
            errors++; $display("FAIL reset_mid_ring: got %h want %h", dut_vec(), 14'd0);
        end
        set_en = 1; inc = 1; dec = 1; cycle();
        sel = 1; cycle(); sel = 0; cycle();
        inc = 0; dec = 0;
        checks++;
        if ({al_hrs, al_min, field} !== {5'd0, 6'd0, 1'b1}) begin
            errors++; $display("FAIL inc_dec_same: got %0d:%0d f%0d want 0:0 f1", al_hrs, al_min, field);
        end
        set_en = 0; cycle();
    endtask

    task automatic test_random();
        bit set_lvl = 0;
        set_alarm(13, 7);
        arm = 1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 2) set_lvl = !set_lvl;
            set_en = set_lvl;
            arm    = 1'($urandom_range(0, 199) != 0);
            sel    = 1'($urandom_range(0, 9) == 0);
            inc    = 1'($urandom_range(0, 9) == 0);
            dec    = 1'($urandom_range(0, 9) == 0);
            snooze = 1'($urandom_range(0, 29) == 0);
            stop   = 1'($urandom_range(0, 39) == 0);
            rst    = 1'($urandom_range(0, 999) == 0);
            if ($urandom_range(0, 99) < 3)
                tod = (m_al_h * 3600 + m_al_m * 60 + 86400 - $urandom_range(1, 3)) % 86400;
            else if ($urandom_range(0, 99) < 40)
                tod = (tod + 1) % 86400;
            drive_tod();
            cycle();
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++; $display("FAIL random[%0d]: got %h want %h", i, dut_vec(), model_vec());
            end
        end
        {sel, inc, dec, snooze, stop, rst, set_en} = '0;
        arm = 1;
        cycle();
    endtask

    initial begin
        m_al_h = 0; m_al_m = 0; m_field = 0; m_mode = M_IDLE;
        m_ring_left = 0; m_snz_left = 0; m_prev_sec = 0;
        test_reset();
        test_edit();
        test_trigger();
        test_timeout();
        test_snooze();
        test_priority();
        test_reset_mid_ring();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
